// File: rtl/riscv_pkg.sv
// Shared front-end definitions: data widths, redirect-source encoding and
// the fetch-address alignment helper.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   typedef enum logic [1:0] {
      REDIR_NONE = 2'd0,
      REDIR_PRED = 2'd1,
      REDIR_EX   = 2'd2
   } redir_src_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handoff and the
// predicted/execute redirect inputs. master = fetch side, slave = environment.
interface fetch_unit_if;
   import riscv_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic [ILEN-1:0] o_instr;
   logic [XLEN-1:0] o_pc;
   logic            o_valid;
   logic            i_ready;
   logic            bc_taken;
   logic [XLEN-1:0] bc_pc;
   logic            ex_redirect;
   logic [XLEN-1:0] ex_target;

   modport master (
      output imem_req, imem_addr, o_instr, o_pc, o_valid,
      input  imem_rdata, i_ready, bc_taken, bc_pc, ex_redirect, ex_target
   );

   modport slave (
      input  imem_req, imem_addr, o_instr, o_pc, o_valid,
      output imem_rdata, i_ready, bc_taken, bc_pc, ex_redirect, ex_target
   );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO with push, pop, flush and count.
// Flush drops every entry; a push is accepted at full occupancy only alongside a pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify push/pop against current occupancy.
   always_comb begin
      do_pop_s  = pop && (count_r != '0);
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
   end

   // Storage, wrapping pointers and occupancy counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == '0);

endmodule

// File: rtl/fetch_unit.sv
// Two-stage instruction fetch (F1 request, F2 capture into fetch_fifo) with
// predicted and execute redirects. Define FETCH_PERF_EN for the perf counters.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FBUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetch_cnt,
   output logic [31:0]  perf_redir_cnt
`endif
);
   localparam int CW = $clog2(FBUF_DEPTH + 1);
   localparam int PW = CW + 1;

   logic [XLEN-1:0]      pc_r;
   logic [XLEN-1:0]      pc_next_s;
   logic                 inflight_r;
   logic [XLEN-1:0]      inflight_pc_r;
   logic                 pop_s;
   logic                 req_s;
   logic                 flush_s;
   logic [PW-1:0]        pending_s;
   redir_src_e           redir_s;
   logic [CW-1:0]        count_s;
   logic                 empty_s;
   logic [XLEN+ILEN-1:0] head_s;

   // Redirect arbitration, request throttle and next-PC selection.
   always_comb begin
      pop_s   = !empty_s && bus.i_ready;
      redir_s = REDIR_NONE;
      if (bus.ex_redirect) begin
         redir_s = REDIR_EX;
      end else if (pop_s && bus.bc_taken) begin
         redir_s = REDIR_PRED;
      end else begin
         redir_s = REDIR_NONE;
      end
      flush_s = (redir_s != REDIR_NONE);
      // A slot freed by this cycle's pop may be refilled by this cycle's request.
      pending_s = PW'(count_s) + PW'(inflight_r) - PW'(pop_s);
      req_s     = !reset && (pending_s < PW'(FBUF_DEPTH));
      case (redir_s)
         REDIR_EX:   pc_next_s = word_align(bus.ex_target);
         REDIR_PRED: pc_next_s = word_align(bus.bc_pc);
         REDIR_NONE: pc_next_s = req_s ? (pc_r + 32'd4) : pc_r;
         default:    pc_next_s = pc_r;
      endcase
   end

   // PC and in-flight tracking; a request issued during a redirect is killed.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r          <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= 32'h0000_0000;
      end else begin
         pc_r          <= pc_next_s;
         inflight_r    <= req_s && !flush_s;
         inflight_pc_r <= word_align(pc_r);
      end
   end

   fetch_fifo #(
      .DEPTH (FBUF_DEPTH),
      .WIDTH (XLEN + ILEN)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight_r),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata ({inflight_pc_r, bus.imem_rdata}),
      .rdata (head_s),
      .count (count_s),
      .empty (empty_s)
   );

   assign bus.imem_req  = req_s;
   assign bus.imem_addr = word_align(pc_r);
   assign bus.o_valid   = !empty_s;
   assign bus.o_instr   = head_s[ILEN-1:0];
   assign bus.o_pc      = head_s[XLEN+ILEN-1:ILEN];

`ifdef FETCH_PERF_EN
   // Pop and accepted-redirect counters; coinciding redirects count once.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= 32'd0;
         perf_redir_cnt <= 32'd0;
      end else begin
         perf_fetch_cnt <= perf_fetch_cnt + (pop_s ? 32'd1 : 32'd0);
         perf_redir_cnt <= perf_redir_cnt + (flush_s ? 32'd1 : 32'd0);
      end
   end
`endif

endmodule
